// File: rtl/ppu_cpu_regs.sv
// CPU-facing PPU register file: decodes $2000-$2007 (mirrored), holds ctrl/mask/scroll/status
// state, issues single $2007 VRAM accesses to the arbiter and drives NMI.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no VRAM access outstanding; a $2007 event issues one
// ST_REQ  | VRAM_REQ held with stable addr/data until VRAM_ACK
module ppu_cpu_regs #(
    parameter bit PALETTE_BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  CPU_ADDR,
    input  logic [7:0]  CPU_DATA_IN,
    input  logic        CPU_wren,
    input  logic        CPU_rden,
    output logic [7:0]  CPU_DATA_OUT,
    input  logic        VBLANK_SET,
    input  logic        VBLANK_CLR,
    input  logic        SPR0_SET,
    input  logic        SPR_OVF_SET,
    output logic        NMI,
    output logic [7:0]  CTRL_OUT,
    output logic [7:0]  MASK_OUT,
    output logic [14:0] SCROLL_T,
    output logic [2:0]  FINE_X,
    output logic [13:0] VRAM_ADDR,
    output logic [7:0]  VRAM_WDATA,
    output logic        VRAM_WE,
    output logic        VRAM_REQ,
    input  logic        VRAM_ACK,
    input  logic [7:0]  VRAM_RDATA,
    output logic [7:0]  OAM_ADDR,
    output logic        OAM_WE,
    output logic [7:0]  OAM_WDATA,
    input  logic [7:0]  OAM_RDATA
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_MASK   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_OAMADR = 3'd3;
    localparam logic [2:0] A_OAMDAT = 3'd4;
    localparam logic [2:0] A_SCROLL = 3'd5;
    localparam logic [2:0] A_ADDR   = 3'd6;
    localparam logic [2:0] A_DATA   = 3'd7;

    logic [0:0]  r_state;
    logic        r_strobe_d;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_mask;
    logic [14:0] r_v;
    logic [14:0] r_t;
    logic [2:0]  r_fine_x;
    logic        r_w;
    logic [7:0]  r_io;
    logic [7:0]  r_buf;
    logic [7:0]  r_dout;
    logic        r_vblank;
    logic        r_spr0;
    logic        r_ovf;
    logic        r_nmi;
    logic [13:0] r_vram_addr;
    logic [7:0]  r_vram_wdata;
    logic        r_vram_we;
    logic        r_pal;
    logic [7:0]  r_oam_addr;
    logic        r_oam_we;
    logic [7:0]  r_oam_wdata;

    logic        w_strobe;
    logic        w_event;
    logic        w_wr_ev;
    logic        w_rd_ev;
    logic        w_rd_status;
    logic        w_rd_accept;
    logic        w_vram_issue;
    logic [14:0] w_v_inc;
    logic [14:0] w_v_next;
    logic [7:0]  w_status;
    logic [7:0]  w_rd_data;

    // One event per CPU access; a simultaneous wren/rden counts as a write.
    assign w_strobe    = CPU_wren | CPU_rden;
    assign w_event     = w_strobe & ~r_strobe_d;
    assign w_wr_ev     = w_event & CPU_wren;
    assign w_rd_ev     = w_event & ~CPU_wren;
    assign w_rd_status = w_rd_ev & (CPU_ADDR == A_STATUS);
    assign w_rd_accept = (CPU_ADDR != A_DATA) || (r_state == ST_IDLE);

    assign w_vram_issue = w_event & (CPU_ADDR == A_DATA) & (r_state == ST_IDLE);
    assign w_v_inc      = r_ctrl[2] ? 15'd32 : 15'd1;
    assign w_v_next     = r_v + w_v_inc;

    // A vblank set racing the status read is reported as clear; the flag still ends set.
    assign w_status = {r_vblank & ~VBLANK_SET, r_spr0, r_ovf, r_io[4:0]};

    always_comb begin
        w_rd_data = r_io;
        case (CPU_ADDR)
            A_STATUS: w_rd_data = w_status;
            A_OAMDAT: w_rd_data = OAM_RDATA;
            A_DATA:   w_rd_data = r_buf;
            default:  w_rd_data = r_io;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_strobe_d   <= 1'b0;
            r_ctrl       <= 8'h00;
            r_mask       <= 8'h00;
            r_v          <= 15'h0000;
            r_t          <= 15'h0000;
            r_fine_x     <= 3'd0;
            r_w          <= 1'b0;
            r_io         <= 8'h00;
            r_buf        <= 8'h00;
            r_dout       <= 8'h00;
            r_vblank     <= 1'b0;
            r_spr0       <= 1'b0;
            r_ovf        <= 1'b0;
            r_nmi        <= 1'b0;
            r_vram_addr  <= 14'h0000;
            r_vram_wdata <= 8'h00;
            r_vram_we    <= 1'b0;
            r_pal        <= 1'b0;
            r_oam_addr   <= 8'h00;
            r_oam_we     <= 1'b0;
            r_oam_wdata  <= 8'h00;
        end else begin
            r_strobe_d <= w_strobe;
            r_nmi      <= r_ctrl[7] & r_vblank;

            r_oam_we <= 1'b0;
            if (r_oam_we) begin
                r_oam_addr <= r_oam_addr + 8'd1;
            end

            if (VBLANK_SET) begin
                r_vblank <= 1'b1;
            end else if (VBLANK_CLR || w_rd_status) begin
                r_vblank <= 1'b0;
            end

            if (VBLANK_CLR) begin
                r_spr0 <= 1'b0;
            end else if (SPR0_SET) begin
                r_spr0 <= 1'b1;
            end

            if (VBLANK_CLR) begin
                r_ovf <= 1'b0;
            end else if (SPR_OVF_SET) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_vram_issue) begin
                        r_state      <= ST_REQ;
                        r_vram_addr  <= r_v[13:0];
                        r_vram_we    <= CPU_wren;
                        r_vram_wdata <= CPU_DATA_IN;
                        r_pal        <= PALETTE_BYPASS & ~CPU_wren & (r_v[13:8] == 6'h3F);
                        r_v          <= w_v_next;
                    end
                end
                ST_REQ: begin
                    if (VRAM_ACK) begin
                        r_state   <= ST_IDLE;
                        r_vram_we <= 1'b0;
                        r_pal     <= 1'b0;
                        if (!r_vram_we) begin
                            r_buf <= VRAM_RDATA;
                        end
                        if (r_pal) begin
                            r_dout <= VRAM_RDATA;
                            r_io   <= VRAM_RDATA;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_wr_ev) begin
                r_io <= CPU_DATA_IN;
                case (CPU_ADDR)
                    A_CTRL: begin
                        r_ctrl      <= CPU_DATA_IN;
                        r_t[11:10]  <= CPU_DATA_IN[1:0];
                    end
                    A_MASK:   r_mask     <= CPU_DATA_IN;
                    A_OAMADR: r_oam_addr <= CPU_DATA_IN;
                    A_OAMDAT: begin
                        r_oam_we    <= 1'b1;
                        r_oam_wdata <= CPU_DATA_IN;
                    end
                    A_SCROLL: begin
                        if (!r_w) begin
                            r_t[4:0] <= CPU_DATA_IN[7:3];
                            r_fine_x <= CPU_DATA_IN[2:0];
                            r_w      <= 1'b1;
                        end else begin
                            r_t[14:12] <= CPU_DATA_IN[2:0];
                            r_t[9:5]   <= CPU_DATA_IN[7:3];
                            r_w        <= 1'b0;
                        end
                    end
                    A_ADDR: begin
                        if (!r_w) begin
                            r_t[13:8] <= CPU_DATA_IN[5:0];
                            r_t[14]   <= 1'b0;
                            r_w       <= 1'b1;
                        end else begin
                            r_t[7:0] <= CPU_DATA_IN;
                            r_v      <= {r_t[14:8], CPU_DATA_IN};
                            r_w      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // A $2007 read arriving while busy is dropped and leaves the read data alone.
            if (w_rd_ev && w_rd_accept) begin
                r_dout <= w_rd_data;
                r_io   <= w_rd_data;
            end
            if (w_rd_status) begin
                r_w <= 1'b0;
            end
        end
    end

    assign CPU_DATA_OUT = r_dout;
    assign NMI          = r_nmi;
    assign CTRL_OUT     = r_ctrl;
    assign MASK_OUT     = r_mask;
    assign SCROLL_T     = r_t;
    assign FINE_X       = r_fine_x;
    assign VRAM_ADDR    = r_vram_addr;
    assign VRAM_WDATA   = r_vram_wdata;
    assign VRAM_WE      = r_vram_we;
    assign VRAM_REQ     = (r_state == ST_REQ);
    assign OAM_ADDR     = r_oam_addr;
    assign OAM_WE       = r_oam_we;
    assign OAM_WDATA    = r_oam_wdata;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Bench for ppu_cpu_regs: directed CPU accesses, a register-level reference model compared
// every cycle, and hand-computed literal expectations.
module tb_ppu_cpu_regs;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  CPU_ADDR = 3'd0;
    logic [7:0]  CPU_DATA_IN = 8'h00;
    logic        CPU_wren = 1'b0;
    logic        CPU_rden = 1'b0;
    logic [7:0]  CPU_DATA_OUT;
    logic        VBLANK_SET = 1'b0;
    logic        VBLANK_CLR = 1'b0;
    logic        SPR0_SET = 1'b0;
    logic        SPR_OVF_SET = 1'b0;
    logic        NMI;
    logic [7:0]  CTRL_OUT;
    logic [7:0]  MASK_OUT;
    logic [14:0] SCROLL_T;
    logic [2:0]  FINE_X;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_WDATA;
    logic        VRAM_WE;
    logic        VRAM_REQ;
    logic        VRAM_ACK = 1'b0;
    logic [7:0]  VRAM_RDATA = 8'h00;
    logic [7:0]  OAM_ADDR;
    logic        OAM_WE;
    logic [7:0]  OAM_WDATA;
    logic [7:0]  OAM_RDATA;

    int checks = 0;
    int errors = 0;
    int oam_we_cnt = 0;
    logic [7:0] rdv;

    assign OAM_RDATA = OAM_ADDR ^ 8'hC3;

    ppu_cpu_regs #(.PALETTE_BYPASS(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_ADDR(CPU_ADDR), .CPU_DATA_IN(CPU_DATA_IN),
        .CPU_wren(CPU_wren), .CPU_rden(CPU_rden), .CPU_DATA_OUT(CPU_DATA_OUT),
        .VBLANK_SET(VBLANK_SET), .VBLANK_CLR(VBLANK_CLR),
        .SPR0_SET(SPR0_SET), .SPR_OVF_SET(SPR_OVF_SET), .NMI(NMI),
        .CTRL_OUT(CTRL_OUT), .MASK_OUT(MASK_OUT), .SCROLL_T(SCROLL_T), .FINE_X(FINE_X),
        .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA), .VRAM_WE(VRAM_WE),
        .VRAM_REQ(VRAM_REQ), .VRAM_ACK(VRAM_ACK), .VRAM_RDATA(VRAM_RDATA),
        .OAM_ADDR(OAM_ADDR), .OAM_WE(OAM_WE), .OAM_WDATA(OAM_WDATA), .OAM_RDATA(OAM_RDATA)
    );

    initial forever #5 CLK = ~CLK;

    // Reference model: architectural register state, advanced once per rising edge.
    bit          m_valid = 0;
    bit          m_prev_any;
    logic [7:0]  m_ctrl, m_mask, m_io, m_buf, m_dout, m_oam_addr, m_oam_wdata, m_wdata;
    logic [14:0] m_t, m_v;
    logic [13:0] m_addr;
    logic [2:0]  m_fx;
    bit          m_w, m_vb, m_s0, m_ov, m_nmi, m_req, m_we, m_pal, m_oam_we;

    task automatic model_reset();
        m_valid = 1; m_prev_any = 0;
        m_ctrl = 0; m_mask = 0; m_io = 0; m_buf = 0; m_dout = 0;
        m_oam_addr = 0; m_oam_wdata = 0; m_wdata = 0; m_t = 0; m_v = 0; m_addr = 0; m_fx = 0;
        m_w = 0; m_vb = 0; m_s0 = 0; m_ov = 0; m_nmi = 0; m_req = 0; m_we = 0; m_pal = 0;
        m_oam_we = 0;
    endtask

    task automatic model_issue(input bit is_wr, input logic [7:0] d);
        m_req  = 1;
        m_addr = m_v[13:0];
        m_we   = is_wr;
        m_wdata = d;
        m_pal  = !is_wr && (m_v[13:8] == 6'h3F);
        m_v    = m_v + (m_ctrl[2] ? 15'd32 : 15'd1);
    endtask

    task automatic model_step();
        bit any, ev, wr, rd, busy;
        logic [7:0] d, ret;
        int a;
        any = CPU_wren || CPU_rden;
        ev  = any && !m_prev_any;
        if (RESET) begin
            model_reset();
            return;
        end
        m_prev_any = any;
        wr = ev && CPU_wren;
        rd = ev && !CPU_wren;
        d  = CPU_DATA_IN;
        a  = int'(CPU_ADDR);
        busy = m_req;
        case (a)
            2: ret = {m_vb && !VBLANK_SET, m_s0, m_ov, m_io[4:0]};
            4: ret = m_oam_addr ^ 8'hC3;
            7: ret = m_buf;
            default: ret = m_io;
        endcase
        m_nmi = m_ctrl[7] && m_vb;
        if (m_oam_we) begin
            m_oam_addr = m_oam_addr + 8'd1;
            m_oam_we = 0;
        end
        if (busy && VRAM_ACK) begin
            m_req = 0;
            if (!m_we) m_buf = VRAM_RDATA;
            if (m_pal) begin
                m_dout = VRAM_RDATA;
                m_io = VRAM_RDATA;
            end
        end
        if (VBLANK_SET) m_vb = 1;
        else if (VBLANK_CLR || (rd && a == 2)) m_vb = 0;
        if (VBLANK_CLR) begin m_s0 = 0; m_ov = 0; end
        else begin
            if (SPR0_SET) m_s0 = 1;
            if (SPR_OVF_SET) m_ov = 1;
        end
        if (wr) begin
            m_io = d;
            case (a)
                0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
                1: m_mask = d;
                3: m_oam_addr = d;
                4: begin m_oam_we = 1; m_oam_wdata = d; end
                5: if (!m_w) begin m_t[4:0] = d[7:3]; m_fx = d[2:0]; m_w = 1; end
                   else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; m_w = 0; end
                6: if (!m_w) begin m_t[13:8] = d[5:0]; m_t[14] = 0; m_w = 1; end
                   else begin m_t[7:0] = d; m_v = {m_t[14:8], d}; m_w = 0; end
                7: if (!busy) model_issue(1, d);
                default: ;
            endcase
        end
        if (rd) begin
            if (a == 7) begin
                if (!busy) begin
                    m_dout = ret; m_io = ret;
                    model_issue(0, d);
                end
            end else begin
                m_dout = ret; m_io = ret;
                if (a == 2) m_w = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("dout", CPU_DATA_OUT, m_dout);
        chk("nmi", NMI, m_nmi);
        chk("ctrl", CTRL_OUT, m_ctrl);
        chk("mask", MASK_OUT, m_mask);
        chk("scroll_t", SCROLL_T, m_t);
        chk("fine_x", FINE_X, m_fx);
        chk("vram_req", VRAM_REQ, m_req);
        chk("oam_addr", OAM_ADDR, m_oam_addr);
        chk("oam_we", OAM_WE, m_oam_we);
        if (m_oam_we) chk("oam_wdata", OAM_WDATA, m_oam_wdata);
        if (m_req) begin
            chk("vram_addr", VRAM_ADDR, m_addr);
            chk("vram_we", VRAM_WE, m_we);
            if (m_we) chk("vram_wdata", VRAM_WDATA, m_wdata);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (OAM_WE === 1'b1) oam_we_cnt++;
        if (m_valid) compare_all();
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        CPU_ADDR = a; CPU_DATA_IN = d; CPU_wren = 1'b1;
        repeat (3) tick();
        CPU_wren = 1'b0;
        tick();
    endtask

    task automatic cpu_rd_pulse(input logic [2:0] a, input bit set, input bit clr,
                                output logic [7:0] d);
        CPU_ADDR = a; CPU_rden = 1'b1; VBLANK_SET = set; VBLANK_CLR = clr;
        tick();
        VBLANK_SET = 1'b0; VBLANK_CLR = 1'b0;
        d = CPU_DATA_OUT;
        repeat (2) tick();
        CPU_rden = 1'b0;
        tick();
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        cpu_rd_pulse(a, 1'b0, 1'b0, d);
    endtask

    task automatic flag_pulse(input bit vs, input bit s0, input bit ov);
        VBLANK_SET = vs; SPR0_SET = s0; SPR_OVF_SET = ov;
        tick();
        VBLANK_SET = 1'b0; SPR0_SET = 1'b0; SPR_OVF_SET = 1'b0;
        tick();
    endtask

    task automatic vram_ack(input logic [7:0] data);
        int n = 0;
        while (VRAM_REQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("vram_req_wait", VRAM_REQ, 1);
        VRAM_ACK = 1'b1; VRAM_RDATA = data;
        tick();
        VRAM_ACK = 1'b0;
        tick();
    endtask

    initial begin
        int cnt0;
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        chk("rst_dout", CPU_DATA_OUT, 8'h00);
        chk("rst_req", VRAM_REQ, 1'b0);
        chk("rst_t", SCROLL_T, 15'h0000);

        // $2006/$2007 write
        cpu_wr(3'd6, 8'h21); cpu_wr(3'd6, 8'h08); cpu_wr(3'd7, 8'h5A);
        chk("w_req", VRAM_REQ, 1'b1);
        chk("w_addr", VRAM_ADDR, 14'h2108);
        chk("w_we", VRAM_WE, 1'b1);
        chk("w_wdata", VRAM_WDATA, 8'h5A);
        vram_ack(8'h00);
        cpu_wr(3'd7, 8'h00);
        chk("w_v_inc1", VRAM_ADDR, 14'h2109);
        vram_ack(8'h00);

        // $2007 reads with +32
        cpu_wr(3'd0, 8'h04); cpu_wr(3'd6, 8'h20); cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, rdv);
        chk("r1_data", rdv, 8'h00);
        chk("r1_addr", VRAM_ADDR, 14'h2000);
        chk("r1_we", VRAM_WE, 1'b0);
        vram_ack(8'h11);
        cpu_rd(3'd7, rdv);
        chk("r2_data", rdv, 8'h11);
        chk("r2_addr", VRAM_ADDR, 14'h2020);
        vram_ack(8'h22);
        cpu_wr(3'd7, 8'h33);
        chk("r_v_inc32", VRAM_ADDR, 14'h2040);
        vram_ack(8'h00);

        // $2005 pair
        cpu_wr(3'd5, 8'h7D); cpu_wr(3'd5, 8'h5E);
        chk("scroll_t_lit", SCROLL_T, 15'h616F);
        chk("fine_x_lit", FINE_X, 3'd5);

        // $2002 side effects and races
        flag_pulse(1'b1, 1'b0, 1'b0);
        cpu_wr(3'd0, 8'h80);
        chk("nmi_on", NMI, 1'b1);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd1, 8'h1F);
        cpu_rd(3'd2, rdv);
        chk("status_9f", rdv, 8'h9F);
        chk("nmi_off", NMI, 1'b0);
        cpu_rd_pulse(3'd2, 1'b1, 1'b0, rdv);
        chk("status_set_race", rdv, 8'h1F);
        chk("nmi_after_race", NMI, 1'b1);
        flag_pulse(1'b0, 1'b1, 1'b1);
        cpu_rd_pulse(3'd2, 1'b0, 1'b1, rdv);
        chk("status_clr_race", rdv, 8'hFF);
        chk("nmi_after_clr", NMI, 1'b0);
        cpu_rd(3'd2, rdv);
        chk("status_cleared", rdv, 8'h1F);

        // w was cleared by the status read, so this pair lands at $3F00: palette bypass
        cpu_wr(3'd6, 8'h3F); cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, rdv);
        chk("pal_old_buf", rdv, 8'h22);
        chk("pal_addr", VRAM_ADDR, 14'h3F00);
        vram_ack(8'h2C);
        chk("pal_bypass", CPU_DATA_OUT, 8'h2C);

        // OAM
        cnt0 = oam_we_cnt;
        cpu_wr(3'd3, 8'hFF); cpu_wr(3'd4, 8'hAB);
        chk("oam_we_pulses", oam_we_cnt - cnt0, 1);
        chk("oam_wrap", OAM_ADDR, 8'h00);
        chk("oam_wdata_lit", OAM_WDATA, 8'hAB);
        cpu_rd(3'd4, rdv);
        chk("oam_read", rdv, 8'hC3);
        chk("oam_no_inc", OAM_ADDR, 8'h00);

        // dropped accesses while a request is pending
        cpu_wr(3'd7, 8'h77);
        chk("drop_addr0", VRAM_ADDR, 14'h3F01);
        cpu_wr(3'd7, 8'h88);
        chk("drop_wdata", VRAM_WDATA, 8'h77);
        chk("drop_addr1", VRAM_ADDR, 14'h3F01);
        cpu_rd(3'd7, rdv);
        chk("drop_rd_dout", rdv, 8'hC3);
        vram_ack(8'h00);
        cpu_wr(3'd7, 8'h99);
        chk("drop_v_once", VRAM_ADDR, 14'h3F02);

        // reset with a request outstanding, then a late ACK
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst2_req", VRAM_REQ, 1'b0);
        chk("rst2_ctrl", CTRL_OUT, 8'h00);
        chk("rst2_we", VRAM_WE, 1'b0);
        chk("rst2_fx", FINE_X, 3'd0);
        VRAM_ACK = 1'b1; VRAM_RDATA = 8'h55;
        tick();
        VRAM_ACK = 1'b0;
        tick();
        chk("late_ack_req", VRAM_REQ, 1'b0);
        chk("late_ack_dout", CPU_DATA_OUT, 8'h00);
        cpu_rd(3'd7, rdv);
        chk("late_ack_buf", rdv, 8'h00);
        chk("post_rst_addr", VRAM_ADDR, 14'h0000);
        vram_ack(8'h00);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
